// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew hazard controller for the pipelined MIPS core.
// Tracks in-flight writers one entry per stage after D and derives the D-stage
// stall, the D-stage forwarding selects and the mult/div busy interlock.
module hazard_scoreboard #(
    parameter int STAGES   = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    localparam int SW      = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [4:0]    d_r_use1,
    input  logic [4:0]    d_r_use2,
    input  logic [TW-1:0] d_t_use1,
    input  logic [TW-1:0] d_t_use2,
    input  logic [4:0]    d_r_new,
    input  logic [TW-1:0] d_t_new,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic          md_busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    // Index 0 is stage 1 (E); index STAGES-1 is the oldest tracked stage.
    logic [4:0]    r_new_q [STAGES];
    logic [TW-1:0] t_new_q [STAGES];
    logic [CW-1:0] md_cnt;
    logic          accept;
    logic          hazard;
    logic [SW-1:0] cand1, cand2;
    logic          rdy1, rdy2;

    assign md_busy = (md_cnt != '0);
    assign accept  = d_valid & ~stall;

    // Stall when any tracked writer of a source is later than its consumer, or on HI/LO use while busy.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if ((d_r_use1 != 5'd0) && (d_r_use1 == r_new_q[k]) && (t_new_q[k] > d_t_use1))
                hazard = 1'b1;
            if ((d_r_use2 != 5'd0) && (d_r_use2 == r_new_q[k]) && (t_new_q[k] > d_t_use2))
                hazard = 1'b1;
        end
        stall = d_valid & (hazard | (d_md_use & md_busy));
    end

    // Forward from the youngest matching writer only, and only once its result exists.
    always_comb begin
        cand1 = '0;
        cand2 = '0;
        rdy1  = 1'b0;
        rdy2  = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites older ones.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if ((d_r_use1 != 5'd0) && (d_r_use1 == r_new_q[k])) begin
                cand1 = SW'(k + 1);
                rdy1  = (t_new_q[k] == '0);
            end
            if ((d_r_use2 != 5'd0) && (d_r_use2 == r_new_q[k])) begin
                cand2 = SW'(k + 1);
                rdy2  = (t_new_q[k] == '0);
            end
        end
        fwd_sel1 = rdy1 ? cand1 : '0;
        fwd_sel2 = rdy2 ? cand2 : '0;
    end

    // Writer shift register: advances every cycle, ageing t_new toward zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_new_q[k] <= '0;
                t_new_q[k] <= '0;
            end
        end else begin
            r_new_q[0] <= accept ? d_r_new : 5'd0;
            t_new_q[0] <= accept ? d_t_new : '0;
            for (int k = 1; k < STAGES; k++) begin
                r_new_q[k] <= r_new_q[k-1];
                t_new_q[k] <= (t_new_q[k-1] != '0) ? t_new_q[k-1] - TW'(1) : '0;
            end
        end
    end

    // Mult/div busy down-counter, loaded on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (accept && d_md_start) begin
            md_cnt <= d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed cases with literal expectations plus
// randomized traffic checked every cycle against an instruction-history model.
module tb_hazard_scoreboard;

    localparam int STAGES   = 3;
    localparam int TW       = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int SW       = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          d_valid = 1'b0;
    logic [4:0]    d_r_use1 = '0, d_r_use2 = '0, d_r_new = '0;
    logic [TW-1:0] d_t_use1 = '0, d_t_use2 = '0, d_t_new = '0;
    logic          d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
    logic          stall, md_busy;
    logic [SW-1:0] fwd_sel1, fwd_sel2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    hazard_scoreboard #(
        .STAGES(STAGES), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_r_use1(d_r_use1), .d_r_use2(d_r_use2),
        .d_t_use1(d_t_use1), .d_t_use2(d_t_use2),
        .d_r_new(d_r_new), .d_t_new(d_t_new),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .md_busy(md_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model: history of accepted instructions ----------------
    typedef struct {
        int         cyc;
        logic [4:0] r;
        int         t;
    } wr_t;

    wr_t hist[$];
    bit  md_valid = 0;
    int  md_cyc = 0;
    int  md_lat = 0;

    // An instruction accepted in cycle c sits in stage (now-c); its result is
    // ready after t_new cycles in the pipe, i.e. remaining = t_new - (stage-1).
    always @(negedge clk) begin
        int  now, s, rem, y1, y2, r1, r2;
        bit  h1, h2, busy_e, stall_e;
        int  sel1_e, sel2_e;
        now = cyc;
        while (hist.size() > 0 && (now - hist[0].cyc) > STAGES) void'(hist.pop_front());
        h1 = 0; h2 = 0; y1 = 99; y2 = 99; r1 = 0; r2 = 0;
        for (int i = 0; i < hist.size(); i++) begin
            s = now - hist[i].cyc;
            if (s >= 1 && s <= STAGES) begin
                rem = hist[i].t - (s - 1);
                if (rem < 0) rem = 0;
                if (d_r_use1 != 0 && hist[i].r == d_r_use1) begin
                    if (rem > int'(d_t_use1)) h1 = 1;
                    if (s < y1) begin y1 = s; r1 = rem; end
                end
                if (d_r_use2 != 0 && hist[i].r == d_r_use2) begin
                    if (rem > int'(d_t_use2)) h2 = 1;
                    if (s < y2) begin y2 = s; r2 = rem; end
                end
            end
        end
        busy_e  = md_valid && (now - md_cyc) >= 1 && (now - md_cyc) <= md_lat;
        stall_e = d_valid && (h1 || h2 || (d_md_use && busy_e));
        sel1_e  = (y1 != 99 && r1 == 0) ? y1 : 0;
        sel2_e  = (y2 != 99 && r2 == 0) ? y2 : 0;
        chk("model_stall", {31'd0, stall}, {31'd0, stall_e});
        chk("model_fwd1", {30'd0, fwd_sel1}, sel1_e);
        chk("model_fwd2", {30'd0, fwd_sel2}, sel2_e);
        chk("model_md_busy", {31'd0, md_busy}, {31'd0, busy_e});
        if (reset) begin
            hist.delete();
            md_valid = 0;
        end else if (d_valid && !stall_e) begin
            hist.push_back('{cyc: now, r: d_r_new, t: int'(d_t_new)});
            if (d_md_start) begin
                md_valid = 1;
                md_cyc   = now;
                md_lat   = d_md_div ? DIV_LAT : MULT_LAT;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [4:0] ru1, input logic [1:0] tu1,
                         input logic [4:0] ru2, input logic [1:0] tu2,
                         input logic [4:0] rn, input logic [1:0] tn,
                         input logic ms, input logic mdv, input logic mu);
        @(posedge clk);
        #1;
        d_valid = v; d_r_use1 = ru1; d_t_use1 = tu1; d_r_use2 = ru2; d_t_use2 = tu2;
        d_r_new = rn; d_t_new = tn; d_md_start = ms; d_md_div = mdv; d_md_use = mu;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic md_case(input logic dv, input int lat);
        int n;
        drive(1, 0, 0, 0, 0, 0, 0, 1, dv, 1);             // mult / div
        #2 chk("md_start_nostall", {31'd0, stall}, 0);
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 1);              // mflo held in D
        #2;
        n = 0;
        while (stall === 1'b1 && n < 30) begin
            chk("md_busy_during_stall", {31'd0, md_busy}, 1);
            n++;
            @(posedge clk);
            #3;
        end
        chk(dv ? "div_stall_cycles" : "mult_stall_cycles", n, lat);
        chk("md_busy_after", {31'd0, md_busy}, 0);
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_fwd1", {30'd0, fwd_sel1}, 0);
        chk("rst_fwd2", {30'd0, fwd_sel2}, 0);
        chk("rst_md_busy", {31'd0, md_busy}, 0);

        // Case 1: lw $8 then addu $9,$8,$8
        drive(1, 0, 0, 0, 0, 8, 2, 0, 0, 0);
        #2 chk("c1_lw", {31'd0, stall}, 0);
        drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
        #2 chk("c1_stall", {31'd0, stall}, 1);
        drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
        #2 chk("c1_release", {31'd0, stall}, 0);
        chk("c1_fwd1", {30'd0, fwd_sel1}, 0);
        chk("c1_fwd2", {30'd0, fwd_sel2}, 0);
        idle(4);

        // Case 2: addu $9 then beq $9,$0
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("c2_stall", {31'd0, stall}, 1);
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("c2_release", {31'd0, stall}, 0);
        chk("c2_fwd1", {30'd0, fwd_sel1}, 2);
        chk("c2_fwd2", {30'd0, fwd_sel2}, 0);
        idle(4);

        // Case 3: two ready writers of $5, youngest wins
        drive(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        drive(1, 5, 0, 5, 0, 0, 0, 0, 0, 0);
        #2 chk("c3_stall", {31'd0, stall}, 0);
        chk("c3_fwd1", {30'd0, fwd_sel1}, 1);
        chk("c3_fwd2", {30'd0, fwd_sel2}, 1);
        idle(4);

        // Youngest not ready but t_new == t_use: no stall, no forward despite ready older entry
        drive(1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 5, 2, 0, 0, 0);
        drive(1, 5, 2, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("c3b_stall", {31'd0, stall}, 0);
        chk("c3b_fwd1", {30'd0, fwd_sel1}, 0);
        idle(4);

        // Case 4: writers to $0 and bubbles never match
        drive(1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 7, 3, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 7, 0, 0, 0, 0, 0, 0);
            #2 chk("c4_stall", {31'd0, stall}, 0);
            chk("c4_fwd1", {30'd0, fwd_sel1}, 0);
            chk("c4_fwd2", {30'd0, fwd_sel2}, 0);
        end
        idle(4);

        // Case 5: mult then div busy windows
        md_case(1'b0, MULT_LAT);
        md_case(1'b1, DIV_LAT);

        // Case 6a: reset during a load-use stall
        drive(1, 0, 0, 0, 0, 8, 2, 0, 0, 0);
        drive(1, 8, 0, 8, 0, 9, 1, 0, 0, 0);
        #2 chk("c6a_stall", {31'd0, stall}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #2 chk("c6a_stall_after", {31'd0, stall}, 0);
        chk("c6a_fwd1", {30'd0, fwd_sel1}, 0);
        chk("c6a_fwd2", {30'd0, fwd_sel2}, 0);
        chk("c6a_md_busy", {31'd0, md_busy}, 0);
        idle(4);

        // Case 6b: reset during a mult busy window
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 1);
        #2 chk("c6b_busy", {31'd0, md_busy}, 1);
        chk("c6b_stall", {31'd0, stall}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #2 chk("c6b_busy_after", {31'd0, md_busy}, 0);
        chk("c6b_stall_after", {31'd0, stall}, 0);
        idle(4);

        // Randomized traffic, checked every cycle by the model
        repeat (3000) begin
            logic ms;
            @(posedge clk);
            #1;
            ms         = ($urandom_range(0, 19) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            d_valid    = ($urandom_range(0, 9) != 0);
            d_r_use1   = 5'($urandom_range(0, 3));
            d_r_use2   = 5'($urandom_range(0, 3));
            d_t_use1   = 2'($urandom_range(0, 3));
            d_t_use2   = 2'($urandom_range(0, 3));
            d_r_new    = 5'($urandom_range(0, 3));
            d_t_new    = 2'($urandom_range(0, 3));
            d_md_start = ms;
            d_md_div   = 1'($urandom_range(0, 1));
            d_md_use   = ms | ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        idle(4);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
